tone_sequencer: RTL and testbench

Plays a stored sequence of chromatic notes through a single square-wave tone generator on the badge audio output. It replaces button-held tone selection with a 16-entry note/duration program. The program is loaded over a simple write port and started and stopped by pulses. It sits between the CPU/button logic and the `pwmout` pin, and owns the only tone divider.

---
 rtl/tone_sequencer.sv | 166 ++++++++++++++++
 tb/tb_tone_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// 16-entry note/duration sequencer driving a single square-wave tone divider.
// Optional `TONE_SEQ_GAP_EN` inserts one silent tick after every note.
module tone_sequencer #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic       audio,
  output logic       busy,
  output logic [3:0] step,
  output logic       done
);
  localparam int PW = $clog2(TICK_DIV);

`ifdef TONE_SEQ_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;
`endif

  state_t        state, state_nx;
  logic [7:0]    ram [DEPTH];
  logic [7:0]    entry;
  logic [3:0]    note, dur, ticks;
  logic [PW-1:0] pre;
  logic [13:0]   tone_cnt, half;
  logic          tick_end, note_end, rest;
  logic [3:0]    step_nx;
  logic          done_nx;

  // Half-period of each chromatic code; odd divisors truncate.
  function automatic logic [13:0] half_period(input logic [3:0] code);
    logic [13:0] div;
    case (code)
      4'd0:    div = 14'd15289;
      4'd1:    div = 14'd14431;
      4'd2:    div = 14'd13621;
      4'd3:    div = 14'd12856;
      4'd4:    div = 14'd12135;
      4'd5:    div = 14'd11454;
      4'd6:    div = 14'd10811;
      4'd7:    div = 14'd10204;
      4'd8:    div = 14'd9631;
      4'd9:    div = 14'd9091;
      4'd10:   div = 14'd8581;
      4'd11:   div = 14'd8099;
      4'd12:   div = 14'd7644;
      default: div = 14'd0;
    endcase
    return div >> 1;
  endfunction

  assign entry    = ram[step];
  assign half     = half_period(note);
  assign rest     = (note > 4'd12);
  assign tick_end = (pre == PW'(TICK_DIV - 1));
  assign note_end = tick_end && (ticks == dur - 4'd1);
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    step_nx  = step;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_FETCH;
          step_nx  = 4'd0;
        end
      end
      S_FETCH: begin
        if (entry[3:0] != 4'd0) begin
          state_nx = S_PLAY;
        end else if (step == 4'd0) begin
          state_nx = S_IDLE;
        end else if (loop) begin
          step_nx = 4'd0;
        end else begin
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end
      end
      S_PLAY: begin
        if (note_end) begin
          if (step == 4'd15 && !loop) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
          end else begin
            step_nx = step + 4'd1;
`ifdef TONE_SEQ_GAP_EN
            state_nx = S_GAP;
`else
            state_nx = S_FETCH;
`endif
          end
        end
      end
`ifdef TONE_SEQ_GAP_EN
      S_GAP: begin
        if (tick_end) state_nx = S_FETCH;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
    // Abort beats everything, including a same-cycle start.
    if (stop) begin
      state_nx = S_IDLE;
      step_nx  = step;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      step     <= 4'd0;
      done     <= 1'b0;
      audio    <= 1'b0;
      note     <= 4'd0;
      dur      <= 4'd0;
      ticks    <= 4'd0;
      pre      <= '0;
      tone_cnt <= 14'd0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'd0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      done  <= done_nx;
      if (wr_en) ram[wr_addr] <= wr_data;
      case (state)
        S_FETCH: begin
          // Latched copy keeps the current note immune to rewrites.
          note     <= entry[7:4];
          dur      <= entry[3:0];
          ticks    <= 4'd0;
          pre      <= '0;
          tone_cnt <= 14'd0;
          audio    <= 1'b0;
        end
        S_PLAY: begin
          pre <= tick_end ? '0 : pre + 1'b1;
          if (tick_end) ticks <= ticks + 4'd1;
          if (tone_cnt == half - 14'd1) begin
            tone_cnt <= 14'd0;
            audio    <= ~audio & ~rest;
          end else begin
            tone_cnt <= tone_cnt + 14'd1;
          end
        end
`ifdef TONE_SEQ_GAP_EN
        S_GAP: pre <= tick_end ? '0 : pre + 1'b1;
`endif
        default: ;
      endcase
      if (state_nx != S_PLAY) audio <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized/directed bench for tone_sequencer: a timeline model predicts every
// output change; a monitor pops and compares whenever the outputs move.
module tb_tone_sequencer;
  localparam int T = 520;
`ifdef TONE_SEQ_GAP_EN
  localparam int GAPC = T;
`else
  localparam int GAPC = 0;
`endif
  localparam int NEVER = 32'h7fff_ffff;

  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0, loop = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic       audio, busy, done;
  logic [3:0] step;

  tone_sequencer #(.DEPTH(16), .TICK_DIV(T)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop),
    .audio(audio), .busy(busy), .step(step), .done(done)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int t; logic a; logic [3:0] s; logic b; logic d;} ev_t;
  ev_t  exp_q[$];
  ev_t  mev;
  int   total = 0, bad = 0;
  logic [7:0] prog [16];
  logic [7:0] mprog [16];
  logic       ma = 1'b0, mb = 1'b0, md = 1'b0;
  logic [3:0] ms = 4'd0;
  int divs [13] = '{15289, 14431, 13621, 12856, 12135, 11454, 10811, 10204,
                    9631, 9091, 8581, 8099, 7644};

  function automatic void put(int t, logic a, logic [3:0] s, logic b, logic d);
    ev_t e;
    if ({a, s, b, d} == {ma, ms, mb, md}) return;
    e.t = t; e.a = a; e.s = s; e.b = b; e.d = d;
    exp_q.push_back(e);
    ma = a; ms = s; mb = b; md = d;
  endfunction

  function automatic bit emit(int lim, int t, logic a, logic [3:0] s, logic b, logic d);
    if (t >= lim) return 1'b0;
    put(t, a, s, b, d);
    return 1'b1;
  endfunction

  // Timeline of output changes for a run started at edge S, aborted at edge X.
  task automatic model(input int S, input int X, input bit lp, input bit by_rst);
    int t, s, L, h, e2, guard;
    logic [3:0] n, d;
    bit fin;
    fin = 1'b0; t = S; s = 0; guard = 0;
    if (emit(X, S, 1'b0, 4'd0, 1'b1, 1'b0)) begin
      while (!fin && t < X && guard < 1000) begin
        guard++;
        n = mprog[s][7:4];
        d = mprog[s][3:0];
        if (d == 4'd0) begin
          if (s == 0) begin
            fin = emit(X, t + 1, 1'b0, 4'(s), 1'b0, 1'b0);
            if (!fin) break;
          end else if (lp) begin
            s = 0; t = t + 1;
            if (!emit(X, t, 1'b0, 4'd0, 1'b1, 1'b0)) break;
          end else begin
            fin = emit(X, t + 1, 1'b0, 4'(s), 1'b0, 1'b1);
            if (fin) put(t + 2, 1'b0, 4'(s), 1'b0, 1'b0); else break;
          end
        end else begin
          L = int'(d) * T;
          if (n < 13) begin
            h = divs[n] / 2;
            for (int k = 1; k * h < L; k++)
              void'(emit(X, t + 1 + k * h, (k % 2 == 1), 4'(s), 1'b1, 1'b0));
          end
          e2 = t + 1 + L;
          if (s == 15 && !lp) begin
            fin = emit(X, e2, 1'b0, 4'(s), 1'b0, 1'b1);
            if (fin) put(e2 + 1, 1'b0, 4'(s), 1'b0, 1'b0); else break;
          end else begin
            s = (s + 1) % 16;
            if (!emit(X, e2, 1'b0, 4'(s), 1'b1, 1'b0)) break;
            t = e2 + GAPC;
          end
        end
      end
    end
    if (X != NEVER && (!fin || by_rst)) put(X, 1'b0, by_rst ? 4'd0 : ms, 1'b0, 1'b0);
  endtask

  logic [6:0] prev;
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en && {audio, step, busy, done} !== prev) begin
      prev = {audio, step, busy, done};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change: t=%0d audio=%b step=%0d busy=%b done=%b",
                 cyc, audio, step, busy, done);
      end else begin
        mev = exp_q.pop_front();
        if (mev.t != cyc || mev.a !== audio || mev.s !== step || mev.b !== busy || mev.d !== done) begin
          bad++;
          $display("FAIL event: got t=%0d a=%b s=%0d b=%b d=%b, want t=%0d a=%b s=%0d b=%b d=%b",
                   cyc, audio, step, busy, done, mev.t, mev.a, mev.s, mev.b, mev.d);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    prog[a] = d;
  endtask

  task automatic load_all();
    for (int i = 0; i < 16; i++) wr(4'(i), prog[i]);
    mprog = prog;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  task automatic fire(input int X, input bit by_rst);
    while (cyc < X - 1) @(negedge clk);
    if (by_rst) rst = 1'b1; else stop = 1'b1;
    @(negedge clk);
    rst = 1'b0; stop = 1'b0;
    if (by_rst) clear_prog();
  endtask

  // dly<0: no abort; dly==0: stop together with start; dly>=2: abort at S+dly.
  task automatic kick(input bit lp, input int dly, input bit by_rst, output int S);
    int X;
    @(negedge clk);
    loop = lp;
    S = cyc + 1;
    X = (dly >= 0) ? S + dly : NEVER;
    model(S, X, lp, by_rst);
    start = 1'b1;
    stop  = (dly == 0);
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    if (dly >= 2) fire(X, by_rst);
  endtask

  task automatic drain(input string nm, input int S, input int budget);
    while (exp_q.size() != 0 && cyc < S + budget) @(negedge clk);
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected events never seen, first due t=%0d", nm, exp_q.size(), exp_q[0].t);
      exp_q.delete();
    end
  endtask

  initial begin
    int S, lim, n, dly;
    bit lp;
    clear_prog();
    repeat (3) @(negedge clk);
    chk("rst_audio", int'(audio), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    prev = {audio, step, busy, done};
    mon_en = 1'b1;

    mprog = prog;
    kick(1'b0, -1, 1'b0, S); drain("empty_after_reset", S, 100);

    clear_prog(); prog[0] = 8'h03; prog[1] = 8'h72; load_all();
    kick(1'b0, 0, 1'b0, S);
    repeat (3) @(negedge clk);
    chk("start_stop_same_busy", int'(busy), 0);
    drain("start_stop_same", S, 100);

    kick(1'b0, -1, 1'b0, S); drain("c3_g3", S, 10000);

    clear_prog(); prog[0] = 8'hCF; load_all();
    kick(1'b0, -1, 1'b0, S); drain("c4_toggle", S, 20000);

    clear_prog(); prog[0] = 8'hE2; load_all();
    kick(1'b0, -1, 1'b0, S); drain("rest", S, 5000);

    clear_prog(); prog[0] = 8'h11; load_all();
    kick(1'b1, 2000, 1'b0, S); drain("loop_stop", S, 5000);
    chk("loop_stop_busy", int'(busy), 0);
    chk("loop_stop_audio", int'(audio), 0);

    for (int i = 0; i < 16; i++) prog[i] = {4'(i), 4'd1};
    load_all();
    kick(1'b0, -1, 1'b0, S);
    repeat (50) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    drain("all16_noloop", S, 40000);

    kick(1'b1, 16 * (T + 1 + GAPC) + 1500, 1'b0, S); drain("all16_loop", S, 40000);

    clear_prog(); prog[0] = 8'h31; prog[1] = 8'h52; prog[2] = 8'h41; load_all();
    mprog[2] = 8'h92;
    kick(1'b0, -1, 1'b0, S);
    lim = cyc + 5000;
    while (step != 4'd1 && cyc < lim) @(negedge clk);
    chk("reach_step1", int'(step), 1);
    repeat (5) @(negedge clk);
    wr(4'd1, 8'h00);
    wr(4'd2, 8'h92);
    drain("rewrite", S, 10000);

    clear_prog(); prog[0] = 8'h55; load_all();
    kick(1'b0, 700, 1'b1, S);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_step", int'(step), 0);
    drain("rst_mid", S, 2000);
    mprog = prog;
    kick(1'b0, -1, 1'b0, S); drain("empty_after_rst", S, 100);

    for (int r = 0; r < 3; r++) begin
      clear_prog();
      n = $urandom_range(2, 4);
      for (int i = 0; i < n; i++) prog[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(1, 2))};
      load_all();
      lp  = 1'($urandom_range(0, 1));
      dly = lp ? $urandom_range(600, 3000) : -1;
      kick(lp, dly, 1'b0, S);
      drain("random", S, 20000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
